// File: rtl/bounded_updown_counter.sv
`default_nettype none
// =============================================================================
// Module   : bounded_updown_counter
// Brief    : Up/down counter bounded to [MIN_VAL, MAX_VAL] with load, wrap or
//            saturate mode, terminal-count and load-error pulses.
// Revision : 1.0 - initial parametrised release
// =============================================================================
module bounded_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MIN_VAL = 3,
  parameter int MAX_VAL = 13,
  parameter int RST_VAL = 13
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             ud_i,
  input  logic             sat_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_min_o,
  output logic             at_max_o,
  output logic             tc_o,
  output logic             load_err_o
);

  localparam logic [WIDTH-1:0] c_min = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] c_rst = WIDTH'(RST_VAL);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("bounded_updown_counter: WIDTH must be within 2..16");
  end
  if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL || MAX_VAL > (1 << WIDTH) - 1) begin : g_bad_bounds
    $error("bounded_updown_counter: need 0 <= MIN_VAL < MAX_VAL <= 2**WIDTH-1");
  end
  if (RST_VAL < MIN_VAL || RST_VAL > MAX_VAL) begin : g_bad_rst
    $error("bounded_updown_counter: RST_VAL must lie within MIN_VAL..MAX_VAL");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             load_err_q, load_err_d;
  logic             din_ok;

  assign din_ok = (din_i >= c_min) && (din_i <= c_max);

  // Bounds are compared before stepping, so count never leaves the range.
  always_comb begin
    count_d    = count_q;
    tc_d       = 1'b0;
    load_err_d = 1'b0;
    if (load_i) begin
      if (din_ok) begin
        count_d = din_i;
      end else begin
        count_d    = c_rst;
        load_err_d = 1'b1;
      end
    end else if (en_i) begin
      if (ud_i) begin
        if (count_q < c_max) begin
          count_d = count_q + 1'b1;
        end else begin
          tc_d    = 1'b1;
          count_d = sat_i ? count_q : c_min;
        end
      end else begin
        if (count_q > c_min) begin
          count_d = count_q - 1'b1;
        end else begin
          tc_d    = 1'b1;
          count_d = sat_i ? count_q : c_max;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= c_rst;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign count_o    = count_q;
  assign at_min_o   = (count_q == c_min);
  assign at_max_o   = (count_q == c_max);
  assign tc_o       = tc_q;
  assign load_err_o = load_err_q;

endmodule
`default_nettype wire

// File: doc/bounded_updown_counter.md
Name: bounded_updown_counter

Overview:
- Parametrised successor to the team's fixed 3-to-13 loadable up/down counter.
- Counts up or down between programmable bounds MIN_VAL..MAX_VAL.
- Adds count enable, selectable wrap/saturate mode, terminal-count and load-error pulses, and bound flags.
- Used as a general range counter (slot/sequence indexing) in the verification-target designs.

Parameters:
WIDTH, 4, counter and din width in bits (2..16)
MIN_VAL, 3, lowest legal count value
MAX_VAL, 13, highest legal count value; must satisfy MIN_VAL < MAX_VAL <= 2**WIDTH-1
RST_VAL, 13, value on reset and on illegal load; must satisfy MIN_VAL <= RST_VAL <= MAX_VAL

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
en  input  1  count enable; no effect while load=1
load  input  1  synchronous load request
din  input  WIDTH  load value
ud  input  1  direction: 1 = up, 0 = down
sat  input  1  bound mode: 1 = saturate, 0 = wrap
count  output  WIDTH  current count (registered)
at_min  output  1  combinational, count == MIN_VAL
at_max  output  1  combinational, count == MAX_VAL
tc  output  1  registered terminal-count pulse
load_err  output  1  registered pulse: last load value was out of range

Behaviour:
- Reset (reset=0, asynchronous): count=RST_VAL, tc=0, load_err=0. The outputs hold these values while reset is low. The first update occurs on the first rising clock edge after reset deasserts.
- Priority per rising edge: load > en > hold.
- Load (load=1):
  - MIN_VAL <= din <= MAX_VAL: count<=din, load_err<=0.
  - Otherwise: count<=RST_VAL, load_err<=1 for one cycle.
  - tc<=0 on any load cycle.
- Count (load=0, en=1, ud=1):
  - count<MAX_VAL: count<=count+1, tc<=0.
  - count==MAX_VAL, sat=0: count<=MIN_VAL, tc<=1.
  - count==MAX_VAL, sat=1: count holds, tc<=1.
- Count (load=0, en=1, ud=0):
  - count>MIN_VAL: count<=count-1, tc<=0.
  - count==MIN_VAL, sat=0: count<=MAX_VAL, tc<=1.
  - count==MIN_VAL, sat=1: count holds, tc<=1.
- Hold (load=0, en=0): count unchanged, tc<=0, load_err<=0.
- tc and load_err are single-cycle pulses. In saturate mode, tc stays high every cycle that en=1 and the counter pushes against the bound.
- Latency: count, tc and load_err reflect the decision one edge later. at_min and at_max follow count with no added latency.
- Invariant: count is always in [MIN_VAL, MAX_VAL]. No arithmetic overflow of WIDTH bits is possible because comparisons happen before the increment or decrement.
- Direction or mode changes take effect on the same edge they are sampled. No pipeline state exists.
- Reset mid-count: count snaps to RST_VAL immediately (asynchronous), and both pulses clear.
- Parameter violations are rejected at elaboration by an assertion or $error. No runtime check is made.

Test Plan:
1. Assert reset=0 mid-stream while counting up from 7 -> count=13, tc=0, load_err=0 without waiting for a clock edge. Release reset -> the first edge counts normally.
2. load=1, din=5, then en=1, ud=1, sat=0 for 9 cycles -> 6,7,...,13,3. tc=1 only in the cycle after 13->3. at_max=1 while count=13.
3. load din=4, then en=1, ud=0, sat=0 -> 3, then 13 with tc=1. at_min=1 while count=3.
4. sat=1, count=13, ud=1, en=1 for 3 cycles -> count stays 13, tc=1 all 3 cycles. Then ud=0 -> 12, tc=0.
5. load with din=2, then din=14, then din=15 -> each gives count=13 and a one-cycle load_err=1. load din=3 -> count=3, load_err=0.
6. load=1 with en=1 and count=13, din=8 -> count=8, no increment, tc=0. Then en=0 for 4 cycles -> count stays 8.
